// File: rtl/alu_pkg.sv
// Shared ALU constants: operation codes, the idle code driven while the ALU
// is unowned, and the state encoding of the ALU share arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_LUI  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_IDLE = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Codes with the top bit set are not ALU operations.
  function automatic logic op_illegal(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/arb2_grant.sv
// Two-way combinational grant. Round-robin tie-break on `last` when
// ALU_ARB_RR_EN is defined, fixed priority to requester 0 otherwise.
module arb2_grant (
  input  logic valid0,
  input  logic valid1,
`ifdef ALU_ARB_RR_EN
  input  logic last,
`endif
  output logic grant_any,
  output logic grant_id
);

  assign grant_any = valid0 | valid1;

`ifdef ALU_ARB_RR_EN
  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant_id = valid1;
    if (valid0 && valid1) grant_id = ~last;
  end
`else
  assign grant_id = valid1 & ~valid0;
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one single-cycle ALU between two valid/ready requesters and returns
// each result on that requester's response channel. Tie-break mode: ALU_ARB_RR_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [4:0]        req0_shamt,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [4:0]        req1_shamt,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_err,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_err,

  output logic [3:0]        alu_operation,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,

  output state_t            dbg_state
);

  // Handshake: a request transfers on an edge where valid and ready are both
  // high; ready is only ever offered in IDLE. A response transfers on an
  // edge where rspN_valid and rspN_ready are both high; payload is held until then.

  state_t            state, state_nxt;
  logic              grant_any, grant_id;
  logic              accept, rsp_done;
  logic              owner;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_zero_q, rsp_err_q;

`ifdef ALU_ARB_RR_EN
  logic last;

  arb2_grant u_grant (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last      (last),
    .grant_any (grant_any),
    .grant_id  (grant_id)
  );
`else
  arb2_grant u_grant (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .grant_any (grant_any),
    .grant_id  (grant_id)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant_any & ~grant_id;
        req1_ready = grant_any & grant_id;
        if (grant_any) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        rsp_done   = owner ? rsp1_ready : rsp0_ready;
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_operation <= ALU_IDLE;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_shamt     <= '0;
      owner         <= 1'b0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last          <= 1'b1;
`endif
    end else if (accept) begin
      alu_operation <= grant_id ? req1_op    : req0_op;
      alu_a         <= grant_id ? req1_a     : req0_a;
      alu_b         <= grant_id ? req1_b     : req0_b;
      alu_shamt     <= grant_id ? req1_shamt : req0_shamt;
      owner         <= grant_id;
`ifdef ALU_ARB_RR_EN
      last          <= grant_id;
`endif
    end else if (state == EXEC) begin
      // Illegal ops still spend the EXEC cycle but report a forced zero result.
      rsp_err_q     <= op_illegal(alu_operation);
      rsp_data_q    <= op_illegal(alu_operation) ? '0 : alu_result;
      rsp_zero_q    <= op_illegal(alu_operation) ? 1'b1 : alu_zero;
      alu_operation <= ALU_IDLE;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_shamt     <= '0;
    end
  end

  assign rsp0_data = rsp_data_q;
  assign rsp0_zero = rsp_zero_q;
  assign rsp0_err  = rsp_err_q;
  assign rsp1_data = rsp_data_q;
  assign rsp1_zero = rsp_zero_q;
  assign rsp1_err  = rsp_err_q;
  assign dbg_state = state;

endmodule
